hue_sat_pipe: RTL and testbench

- Parametrised successor to the fixed RGB565 hue stage: fully pipelined RGB to H/S/V converter.
- Accepts RGB565 or RGB888 pixels, selected by parameter.
- Produces hue in degrees plus saturation and value, with a ready/valid backpressure handshake.
- Sits between the camera pixel unpacker and the colour-detect / mask logic; one pixel per clock when unstalled.

---
 rtl/hue_sat_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_hue_sat_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hue_sat_pipe.sv
// hue_sat_pipe: fully pipelined RGB565/RGB888 -> hue/saturation/value converter
// with a ready/valid handshake. The pipeline is a fixed 11 stages: expand and
// max/min, sector and numerators, eight restoring-divider stages, and output.
// Optional feature macro: HUE_MATCH_EN (registers o_match against a hue window).
module hue_sat_pipe #(
    parameter int IN_FMT  = 0,
    parameter int DATA_W  = 24,
    parameter int LATENCY = 11  // datapath below is 11 deep; keep this at 11
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [8:0]        o_hue,
    output logic [7:0]        o_sat,
    output logic [7:0]        o_val,
    output logic              o_valid,
    input  logic              i_ready,
    input  logic [8:0]        i_hue_lo,
    input  logic [8:0]        i_hue_hi,
    input  logic [7:0]        i_sat_min,
    output logic              o_match
);
    localparam int STAGES = LATENCY;
    localparam int DIV_N  = 8;
    localparam logic [1:0] SEC_R = 2'd0, SEC_G = 2'd1, SEC_B = 2'd2;

    logic              adv;
    logic [STAGES:1]   vld_pipe;

    // Whole pipeline moves together; a full output register blocks it only
    // when downstream is not taking the pixel.
    assign adv     = i_ready | ~o_valid;
    assign o_ready = adv;
    assign o_valid = vld_pipe[STAGES];

    // ---------------- stage 1: expand to 8 bits, max/min ----------------
    logic [7:0] r8, g8, b8, mx8, mn8;
    generate
        if (IN_FMT == 0) begin : g_565
            assign r8 = {i_data[15:11], i_data[15:13]};
            assign g8 = {i_data[10:5],  i_data[10:9]};
            assign b8 = {i_data[4:0],   i_data[4:2]};
        end else begin : g_888
            assign r8 = i_data[23:16];
            assign g8 = i_data[15:8];
            assign b8 = i_data[7:0];
        end
    endgenerate

    // Three-way max and min of the expanded channels
    always_comb begin
        mx8 = r8;
        if (g8 > mx8) mx8 = g8;
        if (b8 > mx8) mx8 = b8;
        mn8 = r8;
        if (g8 < mn8) mn8 = g8;
        if (b8 < mn8) mn8 = b8;
    end

    logic [7:0] s1_r, s1_g, s1_b, s1_max, s1_min;
    // Stage 1 register
    always_ff @(posedge i_clk) begin
        if (adv) begin
            s1_r   <= r8;
            s1_g   <= g8;
            s1_b   <= b8;
            s1_max <= mx8;
            s1_min <= mn8;
        end
    end

    // ---------------- stage 2: sector, signed difference, numerators ----------------
    logic [7:0] delta_c, absd_c;
    logic [1:0] sec_c;
    logic       neg_c;

    // Sector priority R > G > B on ties; keep |d| and its sign separately
    always_comb begin
        delta_c = s1_max - s1_min;
        if (s1_r >= s1_g && s1_r >= s1_b) begin
            sec_c  = SEC_R;
            neg_c  = s1_g < s1_b;
            absd_c = neg_c ? s1_b - s1_g : s1_g - s1_b;
        end else if (s1_g >= s1_b) begin
            sec_c  = SEC_G;
            neg_c  = s1_b < s1_r;
            absd_c = neg_c ? s1_r - s1_b : s1_b - s1_r;
        end else begin
            sec_c  = SEC_B;
            neg_c  = s1_r < s1_g;
            absd_c = neg_c ? s1_g - s1_r : s1_r - s1_g;
        end
    end

    // Index 0 holds the stage-2 register; index k the k-th divider stage.
    logic [15:0] hrem [0:DIV_N];
    logic [15:0] srem [0:DIV_N];
    logic [7:0]  hdiv [0:DIV_N];
    logic [7:0]  sdiv [0:DIV_N];
    logic [7:0]  qh   [0:DIV_N];
    logic [7:0]  qs   [0:DIV_N];
    logic [1:0]  sec  [0:DIV_N];
    logic        neg  [0:DIV_N];

    // Stage 2 register: 60*|d| / delta and 255*delta / max set up for division
    always_ff @(posedge i_clk) begin
        if (adv) begin
            hrem[0] <= 16'(absd_c) * 16'd60;
            srem[0] <= 16'(delta_c) * 16'd255;
            hdiv[0] <= delta_c;
            sdiv[0] <= s1_max;
            qh[0]   <= '0;
            qs[0]   <= '0;
            sec[0]  <= sec_c;
            neg[0]  <= neg_c;
        end
    end

    // ---------------- stages 3..10: restoring dividers, MSB first ----------------
    // Both quotients fit in 8 bits because numerator < 256*divisor, so each
    // stage only tests divisor<<bit. A zero divisor never sets a bit.
    generate
        for (genvar k = 1; k <= DIV_N; k++) begin : g_div
            localparam int SH = DIV_N - k;
            logic [15:0] hsub, ssub;
            logic        hbit, sbit;

            // Trial subtraction for quotient bit SH
            always_comb begin
                hsub = 16'(hdiv[k-1]) << SH;
                ssub = 16'(sdiv[k-1]) << SH;
                hbit = (hdiv[k-1] != 8'd0) && (hrem[k-1] >= hsub);
                sbit = (sdiv[k-1] != 8'd0) && (srem[k-1] >= ssub);
            end

            // Divider stage register
            always_ff @(posedge i_clk) begin
                if (adv) begin
                    hrem[k] <= hbit ? hrem[k-1] - hsub : hrem[k-1];
                    srem[k] <= sbit ? srem[k-1] - ssub : srem[k-1];
                    qh[k]   <= qh[k-1] | (8'(hbit) << SH);
                    qs[k]   <= qs[k-1] | (8'(sbit) << SH);
                    hdiv[k] <= hdiv[k-1];
                    sdiv[k] <= sdiv[k-1];
                    sec[k]  <= sec[k-1];
                    neg[k]  <= neg[k-1];
                end
            end
        end
    endgenerate

    // ---------------- stage 11: hue assembly and output ----------------
    logic [8:0] hue_c, qh9;

    // Place the 0..60 offset around the sector base; R-negative wraps below 360
    always_comb begin
        qh9 = {1'b0, qh[DIV_N]};
        case (sec[DIV_N])
            SEC_R:   hue_c = neg[DIV_N] ? ((qh9 == 9'd0) ? 9'd0 : 9'd360 - qh9) : qh9;
            SEC_G:   hue_c = neg[DIV_N] ? 9'd120 - qh9 : 9'd120 + qh9;
            default: hue_c = neg[DIV_N] ? 9'd240 - qh9 : 9'd240 + qh9;
        endcase
        if (hdiv[DIV_N] == 8'd0) hue_c = 9'd0;
    end

    // Valid shift register and output registers; reset drops in-flight pixels
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_pipe <= '0;
            o_hue    <= '0;
            o_sat    <= '0;
            o_val    <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], i_valid};
            o_hue    <= hue_c;
            o_sat    <= qs[DIV_N];
            o_val    <= sdiv[DIV_N];
        end
    end

`ifdef HUE_MATCH_EN
    logic in_win, match_c;

    // Hue window test; lo > hi means the window wraps through 0
    always_comb begin
        if (i_hue_lo <= i_hue_hi) in_win = (hue_c >= i_hue_lo) && (hue_c <= i_hue_hi);
        else                      in_win = (hue_c >= i_hue_lo) || (hue_c <= i_hue_hi);
        match_c = in_win && (qs[DIV_N] >= i_sat_min);
    end

    // Match flag registered alongside the other outputs
    always_ff @(posedge i_clk) begin
        if (i_rst)    o_match <= 1'b0;
        else if (adv) o_match <= match_c;
    end
`else
    assign o_match = 1'b0;
`endif

    // Input bits outside the selected format and the final remainders are not needed
    logic unused_bits;
    assign unused_bits = ^{i_data, i_hue_lo, i_hue_hi, i_sat_min, hrem[DIV_N], srem[DIV_N]};

endmodule

// File: tb/tb_hue_sat_pipe.sv
// Testbench for hue_sat_pipe: an RGB888 instance (main, with backpressure) and
// an RGB565 instance (always ready), checked against a behavioural HSV model.
module tb_hue_sat_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef HUE_MATCH_EN
    localparam bit MATCH_ON = 1'b1;
`else
    localparam bit MATCH_ON = 1'b0;
`endif

    logic        rst;
    logic [23:0] a_data;
    logic        a_ivalid, a_ordy, a_ovalid, a_iready, a_match;
    logic [8:0]  a_hue;
    logic [7:0]  a_sat, a_val;
    logic [15:0] b_data;
    logic        b_ivalid, b_ordy, b_ovalid, b_match;
    logic [8:0]  b_hue;
    logic [7:0]  b_sat, b_val;
    logic [8:0]  win_lo, win_hi;
    logic [7:0]  win_smin;

    hue_sat_pipe #(.IN_FMT(1), .DATA_W(24), .LATENCY(11)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(a_data), .i_valid(a_ivalid), .o_ready(a_ordy),
        .o_hue(a_hue), .o_sat(a_sat), .o_val(a_val), .o_valid(a_ovalid), .i_ready(a_iready),
        .i_hue_lo(win_lo), .i_hue_hi(win_hi), .i_sat_min(win_smin), .o_match(a_match));

    hue_sat_pipe #(.IN_FMT(0), .DATA_W(16), .LATENCY(11)) dut565 (
        .i_clk(clk), .i_rst(rst), .i_data(b_data), .i_valid(b_ivalid), .o_ready(b_ordy),
        .o_hue(b_hue), .o_sat(b_sat), .o_val(b_val), .o_valid(b_ovalid), .i_ready(1'b1),
        .i_hue_lo(win_lo), .i_hue_hi(win_hi), .i_sat_min(win_smin), .o_match(b_match));

    typedef struct { int h; int s; int v; int m; int acc; } exp_t;
    exp_t qa[$], qb[$];
    exp_t a_nxt, b_nxt;
    int   n_tests = 0, n_fail = 0, cyc = 0, n_acc = 0;
    bit   lat_chk, hold, acc_a;
    int   hh, hs, hv, hm;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Behavioural HSV from 8-bit channels, straight from the colour-space rules
    function automatic exp_t model(input int r, input int g, input int b);
        exp_t e;
        int mx, mn, dl, d, base, qh;
        bit inw;
        mx = (r > g) ? r : g;  mx = (mx > b) ? mx : b;
        mn = (r < g) ? r : g;  mn = (mn < b) ? mn : b;
        dl = mx - mn;
        if (r >= g && r >= b) begin d = g - b; base = 0;   end
        else if (g >= b)      begin d = b - r; base = 120; end
        else                  begin d = r - g; base = 240; end
        qh  = (dl == 0) ? 0 : (60 * ((d < 0) ? -d : d)) / dl;
        e.h = (dl == 0) ? 0 : (base + ((d < 0) ? -qh : qh) + 360) % 360;
        e.s = (mx == 0) ? 0 : (255 * dl) / mx;
        e.v = mx;
        if (win_lo <= win_hi) inw = (e.h >= win_lo) && (e.h <= win_hi);
        else                  inw = (e.h >= win_lo) || (e.h <= win_hi);
        e.m = (MATCH_ON && inw && e.s >= win_smin) ? 1 : 0;
        e.acc = 0;
        return e;
    endfunction

    function automatic exp_t model888(input logic [23:0] px);
        return model(int'(px[23:16]), int'(px[15:8]), int'(px[7:0]));
    endfunction

    function automatic exp_t model565(input logic [15:0] px);
        int r5, g6, b5;
        r5 = int'(px[15:11]); g6 = int'(px[10:5]); b5 = int'(px[4:0]);
        return model(r5 * 8 + r5 / 4, g6 * 4 + g6 / 16, b5 * 8 + b5 / 4);
    endfunction

    function automatic exp_t mk(input int h, input int s, input int v, input int m);
        exp_t e;
        e.h = h; e.s = s; e.v = v; e.m = m; e.acc = 0;
        return e;
    endfunction

    // One clock: check outputs / handshake in the current cycle, then advance
    task automatic step();
        exp_t e;
        #1;
        acc_a = 1'b0;
        if (rst) begin
            qa.delete(); qb.delete(); hold = 1'b0;
        end else begin
            chk("o_ready", int'(a_ordy), (a_iready || !a_ovalid) ? 1 : 0);
            chk("b_o_ready", int'(b_ordy), 1);
            if (hold) begin
                chk("hold_valid", int'(a_ovalid), 1);
                chk("hold_hue", int'(a_hue), hh);
                chk("hold_sat", int'(a_sat), hs);
                chk("hold_val", int'(a_val), hv);
                chk("hold_match", int'(a_match), hm);
            end
            if (a_ovalid && a_iready) begin
                if (qa.size() == 0) chk("a_spurious_out", qa.size(), 1);
                else begin
                    e = qa.pop_front();
                    chk("a_hue", int'(a_hue), e.h);
                    chk("a_sat", int'(a_sat), e.s);
                    chk("a_val", int'(a_val), e.v);
                    chk("a_match", int'(a_match), e.m);
                    if (lat_chk) chk("a_latency", cyc - e.acc, 11);
                end
            end
            if (a_ivalid && a_ordy) begin
                e = a_nxt; e.acc = cyc; qa.push_back(e); acc_a = 1'b1; n_acc++;
            end
            hold = a_ovalid && !a_iready;
            hh = int'(a_hue); hs = int'(a_sat); hv = int'(a_val); hm = int'(a_match);
            if (b_ovalid) begin
                if (qb.size() == 0) chk("b_spurious_out", qb.size(), 1);
                else begin
                    e = qb.pop_front();
                    chk("b_hue", int'(b_hue), e.h);
                    chk("b_sat", int'(b_sat), e.s);
                    chk("b_val", int'(b_val), e.v);
                    chk("b_match", int'(b_match), e.m);
                    if (lat_chk) chk("b_latency", cyc - e.acc, 11);
                end
            end
            if (b_ivalid) begin
                e = b_nxt; e.acc = cyc; qb.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        a_ivalid = 1'b0; b_ivalid = 1'b0; a_iready = 1'b1;
        for (int k = 0; k < 60 && (qa.size() + qb.size()) != 0; k++) step();
        chk("drain_empty", qa.size() + qb.size(), 0);
    endtask

    logic [23:0] t888  [0:6] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'hFF00FF, 24'h808080, 24'h804000};
    int          t888h [0:6] = '{0, 120, 240, 60, 300, 0, 30};
    int          t888s [0:6] = '{255, 255, 255, 255, 255, 0, 255};
    int          t888v [0:6] = '{255, 255, 255, 255, 255, 128, 128};
    logic [15:0] t565  [0:3] = '{16'hF800, 16'h07E0, 16'h001F, 16'h0000};
    int          t565h [0:3] = '{0, 120, 240, 0};
    int          t565s [0:3] = '{255, 255, 255, 0};
    int          t565v [0:3] = '{255, 255, 255, 0};
    logic [23:0] tm    [0:2] = '{24'hFF0000, 24'hFF00FF, 24'h808080};
    int          tmh   [0:2] = '{0, 300, 0};
    int          tms   [0:2] = '{255, 255, 0};
    int          tmv   [0:2] = '{255, 255, 128};
    int          tmm   [0:2] = '{1, 0, 0};

    initial begin
        logic [23:0] px;
        bit need;
        int p, t;
        rst = 1'b1; a_data = '0; a_ivalid = 1'b0; a_iready = 1'b1;
        b_data = '0; b_ivalid = 1'b0;
        win_lo = 9'd0; win_hi = 9'd359; win_smin = 8'd0;
        lat_chk = 1'b0; hold = 1'b0; px = '0; need = 1'b1;
        a_nxt = mk(0, 0, 0, 0); b_nxt = mk(0, 0, 0, 0);
        @(negedge clk);
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_valid", int'(a_ovalid), 0);
        chk("rst_hue", int'(a_hue), 0);
        chk("rst_sat", int'(a_sat), 0);
        chk("rst_val", int'(a_val), 0);
        chk("rst_match", int'(a_match), 0);
        chk("rst_ready", int'(a_ordy), 1);
        chk("rst_b_valid", int'(b_ovalid), 0);

        // Directed RGB888 stream, back-to-back, fixed latency
        lat_chk = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a_data = t888[i]; a_ivalid = 1'b1;
            a_nxt = mk(t888h[i], t888s[i], t888v[i], int'(MATCH_ON));
            step();
        end
        drain();

        // Directed RGB565 stream
        for (int i = 0; i < 4; i++) begin
            b_data = t565[i]; b_ivalid = 1'b1;
            b_nxt = mk(t565h[i], t565s[i], t565v[i], int'(MATCH_ON));
            step();
        end
        drain();

        // Hue window: wrapping window, then plain window
        for (int w = 0; w < 2; w++) begin
            win_lo = (w == 0) ? 9'd330 : 9'd0;
            win_hi = (w == 0) ? 9'd30  : 9'd60;
            win_smin = 8'd100;
            for (int i = 0; i < 3; i++) begin
                a_data = tm[i]; a_ivalid = 1'b1;
                a_nxt = mk(tmh[i], tms[i], tmv[i], MATCH_ON ? tmm[i] : 0);
                step();
            end
            drain();
        end
        lat_chk = 1'b0;
        win_lo = 9'd0; win_hi = 9'd359; win_smin = 8'd0;

        // Backpressure: 20 pixels, downstream stalls for 5 cycles at cycle 15
        p = 0; t = 0; need = 1'b1;
        while (p < 20 && t < 200) begin
            if (need) begin px = 24'($urandom); a_nxt = model888(px); need = 1'b0; end
            a_data = px; a_ivalid = 1'b1;
            a_iready = !(t >= 15 && t < 20);
            #1;
            if (t >= 15 && t < 20) chk("bp_o_ready", int'(a_ordy), 0);
            step();
            if (acc_a) begin p++; need = 1'b1; end
            t++;
        end
        chk("bp_accepted", p, 20);
        drain();

        // Reset with 6 pixels in flight; none may emerge
        for (int i = 0; i < 6; i++) begin
            px = 24'($urandom); a_data = px; a_nxt = model888(px); a_ivalid = 1'b1;
            step();
        end
        a_ivalid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", int'(a_ovalid), 0);
        repeat (15) step();
        lat_chk = 1'b1;
        px = 24'h20C0F0; a_data = px; a_nxt = model888(px); a_ivalid = 1'b1;
        step();
        drain();
        lat_chk = 1'b0;

        // Random regression with random handshakes and a random window
        win_lo = 9'($urandom_range(0, 359));
        win_hi = 9'($urandom_range(0, 359));
        win_smin = 8'($urandom_range(0, 255));
        n_acc = 0; need = 1'b1;
        for (int c = 0; c < 60000 && n_acc < 10000; c++) begin
            if (need) begin px = 24'($urandom); a_nxt = model888(px); need = 1'b0; end
            a_data = px;
            a_ivalid = ($urandom_range(0, 3) != 0);
            a_iready = ($urandom_range(0, 3) != 0);
            b_data = 16'($urandom); b_nxt = model565(b_data);
            b_ivalid = ($urandom_range(0, 1) != 0);
            step();
            if (acc_a) need = 1'b1;
        end
        chk("regress_count", n_acc, 10000);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
